// File: rtl/sha2_pkg.sv
// Shared types and constants for the SHA-2 message padding controller.
package sha2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_ZERO = 3'd3,
        ST_LEN  = 3'd4,
        ST_BLK  = 3'd5,
        ST_DONE = 3'd6
    } sha2_state_e;

    localparam logic [63:0] PAD_WORD    = 64'h8000_0000_0000_0000;
    localparam logic [2:0]  IDX_LAST    = 3'd7;
    localparam logic [2:0]  IDX_PRE_LEN = 3'd6;

    // Where a pad or zero store at slot idx leads: the length word needs slot 7 free.
    function automatic sha2_state_e fill_next(input logic [2:0] slot);
        sha2_state_e nx;
        case (slot)
            IDX_PRE_LEN: nx = ST_LEN;
            IDX_LAST:    nx = ST_BLK;
            default:     nx = ST_ZERO;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/sha2_pad_ctrl.sv
// SHA-2 padding controller: sequences data, pad, zero and length stores into 8-word blocks.
// Optional block counter output blk_cnt is enabled with `define SHA2_BLK_CNT_EN.
module sha2_pad_ctrl
    import sha2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic       pkt_vld,
    input  logic       pkt_last,
    output logic       pkt_rdy,
    input  logic [2:0] idx,
    output logic       st_pkt,
    output logic       pad_pkt,
    output logic       zero_pkt,
    output logic       mgln_pkt,
    output logic       clr,
    output logic       blk_vld,
    input  logic       blk_ack,
    output logic       msg_done
`ifdef SHA2_BLK_CNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    sha2_state_e state_r;
    sha2_state_e resume_r;
    sha2_state_e state_nx_s;
    sha2_state_e resume_nx_s;

    logic pkt_rdy_r;
    logic blk_vld_r;
    logic clr_r;
    logic msg_done_r;
    logic accept_s;
    logic st_pkt_s;
    logic pad_pkt_s;
    logic zero_pkt_s;
    logic mgln_pkt_s;

    assign accept_s = pkt_vld & pkt_rdy_r;

    // Next-state and resume-state selection.
    always_comb begin
        state_nx_s  = state_r;
        resume_nx_s = resume_r;
        case (state_r)
            ST_IDLE, ST_DATA: begin
                if (accept_s) begin
                    if (idx == IDX_LAST) begin
                        state_nx_s  = ST_BLK;
                        resume_nx_s = pkt_last ? ST_PAD : ST_DATA;
                    end else begin
                        state_nx_s  = pkt_last ? ST_PAD : ST_DATA;
                        resume_nx_s = resume_r;
                    end
                end else begin
                    state_nx_s  = state_r;
                    resume_nx_s = resume_r;
                end
            end
            ST_PAD, ST_ZERO: begin
                state_nx_s = fill_next(idx);
                if (idx == IDX_LAST) begin
                    resume_nx_s = ST_ZERO;
                end else begin
                    resume_nx_s = resume_r;
                end
            end
            ST_LEN: begin
                // The length word only ever lands in slot 7; keep zero-filling until it is reached.
                if (idx == IDX_LAST) begin
                    state_nx_s  = ST_BLK;
                    resume_nx_s = ST_DONE;
                end else begin
                    state_nx_s  = ST_LEN;
                    resume_nx_s = resume_r;
                end
            end
            ST_BLK: begin
                if (blk_ack) begin
                    state_nx_s  = resume_r;
                    resume_nx_s = ST_IDLE;
                end else begin
                    state_nx_s  = ST_BLK;
                    resume_nx_s = resume_r;
                end
            end
            ST_DONE: begin
                state_nx_s  = ST_IDLE;
                resume_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s  = ST_IDLE;
                resume_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r    <= ST_IDLE;
            resume_r   <= ST_IDLE;
            pkt_rdy_r  <= 1'b1;
            blk_vld_r  <= 1'b0;
            clr_r      <= 1'b0;
            msg_done_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            resume_r   <= resume_nx_s;
            pkt_rdy_r  <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_DATA);
            blk_vld_r  <= (state_nx_s == ST_BLK);
            clr_r      <= (state_nx_s == ST_DONE);
            msg_done_r <= (state_nx_s == ST_DONE);
        end
    end

    // Store strobes: data stores follow the handshake, fill stores follow the state.
    always_comb begin
        st_pkt_s   = 1'b0;
        pad_pkt_s  = 1'b0;
        zero_pkt_s = 1'b0;
        mgln_pkt_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DATA: begin
                st_pkt_s = accept_s;
            end
            ST_PAD: begin
                st_pkt_s  = 1'b1;
                pad_pkt_s = 1'b1;
            end
            ST_ZERO: begin
                st_pkt_s   = 1'b1;
                zero_pkt_s = 1'b1;
            end
            ST_LEN: begin
                st_pkt_s = 1'b1;
                if (idx == IDX_LAST) begin
                    mgln_pkt_s = 1'b1;
                end else begin
                    zero_pkt_s = 1'b1;
                end
            end
            default: begin
                st_pkt_s = 1'b0;
            end
        endcase
    end

    assign pkt_rdy  = pkt_rdy_r;
    assign blk_vld  = blk_vld_r;
    assign clr      = clr_r;
    assign msg_done = msg_done_r;
    assign st_pkt   = st_pkt_s;
    assign pad_pkt  = pad_pkt_s;
    assign zero_pkt = zero_pkt_s;
    assign mgln_pkt = mgln_pkt_s;

`ifdef SHA2_BLK_CNT_EN
    logic [15:0] blk_cnt_r;

    // Acknowledged blocks in the current message, saturating, cleared at message end.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            blk_cnt_r <= 16'd0;
        end else if (state_r == ST_DONE) begin
            blk_cnt_r <= 16'd0;
        end else if ((state_r == ST_BLK) && blk_ack && (blk_cnt_r != 16'hFFFF)) begin
            blk_cnt_r <= blk_cnt_r + 16'd1;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign blk_cnt = blk_cnt_r;
`endif

endmodule

// File: tb/tb_sha2_pad_ctrl.sv
// Scoreboard bench for sha2_pad_ctrl with a behavioural input-datapath model.
module tb_sha2_pad_ctrl;

    typedef enum int {EV_DATA, EV_PAD, EV_ZERO, EV_LEN, EV_BLK, EV_DONE, EV_BAD} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [2:0]  idx;
        logic [63:0] word;
    } ev_t;

    ev_t exp_q[$];
    ev_t e_m;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic pkt_vld = 1'b0;
    logic pkt_last = 1'b0;
    logic blk_ack = 1'b0;
    logic [63:0] pkt_data = 64'd0;
    logic pkt_rdy, st_pkt, pad_pkt, zero_pkt, mgln_pkt, clr, blk_vld, msg_done;
    logic [2:0]  idx_r;
    logic [63:0] bitcnt_r;
`ifdef SHA2_BLK_CNT_EN
    logic [15:0] blk_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int zero_seen = 0;
    int hold = 0;
    int last_hold = 0;
    int ack_delay = 0;
    int blks_in_msg = 0;
    bit ack_auto = 1'b1;
    logic blk_vld_q = 1'b0;
    ev_kind_e k_m;
    logic [63:0] w_m;

    always #5 clk = ~clk;

    sha2_pad_ctrl dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .pkt_vld  (pkt_vld),
        .pkt_last (pkt_last),
        .pkt_rdy  (pkt_rdy),
        .idx      (idx_r),
        .st_pkt   (st_pkt),
        .pad_pkt  (pad_pkt),
        .zero_pkt (zero_pkt),
        .mgln_pkt (mgln_pkt),
        .clr      (clr),
        .blk_vld  (blk_vld),
        .blk_ack  (blk_ack),
        .msg_done (msg_done)
`ifdef SHA2_BLK_CNT_EN
        ,
        .blk_cnt  (blk_cnt)
`endif
    );

    // Input datapath model: slot counter and data bit counter.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            idx_r    <= 3'd0;
            bitcnt_r <= 64'd0;
        end else if (clr) begin
            idx_r    <= 3'd0;
            bitcnt_r <= 64'd0;
        end else if (st_pkt) begin
            idx_r <= idx_r + 3'd1;
            if (!pad_pkt && !zero_pkt && !mgln_pkt) bitcnt_r <= bitcnt_r + 64'd64;
        end
    end

    // Monitor: compares stores, block hand-offs and message end against the scoreboard.
    always @(negedge clk) begin
        if (!rst_b) begin
            blk_vld_q = 1'b0;
            blks_in_msg = 0;
        end else begin
            if (st_pkt) begin
                if (!pad_pkt && !zero_pkt && !mgln_pkt) begin k_m = EV_DATA; w_m = pkt_data; end
                else if (pad_pkt && !zero_pkt && !mgln_pkt) begin k_m = EV_PAD; w_m = 64'h8000_0000_0000_0000; end
                else if (!pad_pkt && zero_pkt && !mgln_pkt) begin k_m = EV_ZERO; w_m = 64'd0; end
                else if (!pad_pkt && !zero_pkt && mgln_pkt) begin k_m = EV_LEN; w_m = bitcnt_r; end
                else begin k_m = EV_BAD; w_m = 64'd0; end
                if (k_m == EV_ZERO) zero_seen++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL store_unexpected got kind=%0d idx=%0d, required none", k_m, idx_r);
                end else begin
                    e_m = exp_q.pop_front();
                    if (k_m !== e_m.kind || idx_r !== e_m.idx || w_m !== e_m.word) begin
                        tests_failed++;
                        $display("FAIL store got kind=%0d idx=%0d word=%h, required kind=%0d idx=%0d word=%h",
                                 k_m, idx_r, w_m, e_m.kind, e_m.idx, e_m.word);
                    end
                end
            end else begin
                tests_run++;
                if (pad_pkt || zero_pkt || mgln_pkt) begin
                    tests_failed++;
                    $display("FAIL strobe_no_store got pad=%b zero=%b len=%b, required 0", pad_pkt, zero_pkt, mgln_pkt);
                end
            end
            if (blk_vld) begin
                tests_run++;
                if (pkt_rdy !== 1'b0 || st_pkt !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL blk_hold got pkt_rdy=%b st_pkt=%b, required 0 0", pkt_rdy, st_pkt);
                end
            end
            if (blk_vld && !blk_vld_q) begin
                tests_run++;
                e_m = (exp_q.size() != 0) ? exp_q.pop_front() : '{EV_BAD, 3'd0, 64'd0};
                if (e_m.kind !== EV_BLK) begin
                    tests_failed++;
                    $display("FAIL blk_event got kind=%0d, required kind=%0d", EV_BLK, e_m.kind);
                end
`ifdef SHA2_BLK_CNT_EN
                tests_run++;
                if (blk_cnt !== 16'(blks_in_msg)) begin
                    tests_failed++;
                    $display("FAIL blk_cnt got %0d, required %0d", blk_cnt, blks_in_msg);
                end
`endif
                blks_in_msg++;
            end
            if (msg_done) begin
                done_cnt++;
                tests_run++;
                e_m = (exp_q.size() != 0) ? exp_q.pop_front() : '{EV_BAD, 3'd0, 64'd0};
                if (e_m.kind !== EV_DONE) begin
                    tests_failed++;
                    $display("FAIL done_event got kind=%0d, required kind=%0d", EV_DONE, e_m.kind);
                end
`ifdef SHA2_BLK_CNT_EN
                tests_run++;
                if (blk_cnt !== 16'(blks_in_msg)) begin
                    tests_failed++;
                    $display("FAIL blk_cnt_done got %0d, required %0d", blk_cnt, blks_in_msg);
                end
`endif
                blks_in_msg = 0;
            end
            tests_run++;
            if (clr !== msg_done) begin
                tests_failed++;
                $display("FAIL clr_pulse got clr=%b, required %b", clr, msg_done);
            end
            blk_vld_q = blk_vld;
        end
    end

    // Hash-core stand-in: acknowledges a block after ack_delay cycles of blk_vld.
    initial begin
        forever begin
            @(negedge clk);
            if (ack_auto) begin
                if (rst_b && blk_vld && !blk_ack) begin
                    hold++;
                    if (hold > ack_delay) blk_ack = 1'b1;
                end else begin
                    if (blk_ack) begin
                        blk_ack = 1'b0;
                        last_hold = hold;
                    end
                    hold = 0;
                end
            end
        end
    end

    function automatic void push_expect(input int n, input logic [63:0] base);
        int pos;
        pos = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{EV_DATA, 3'(pos), base + 64'(i)});
            if (pos == 7) exp_q.push_back('{EV_BLK, 3'd0, 64'd0});
            pos = (pos + 1) % 8;
        end
        exp_q.push_back('{EV_PAD, 3'(pos), 64'h8000_0000_0000_0000});
        if (pos == 7) exp_q.push_back('{EV_BLK, 3'd0, 64'd0});
        pos = (pos + 1) % 8;
        while (pos != 7) begin
            exp_q.push_back('{EV_ZERO, 3'(pos), 64'd0});
            pos++;
        end
        exp_q.push_back('{EV_LEN, 3'd7, 64'(n) * 64'd64});
        exp_q.push_back('{EV_BLK, 3'd0, 64'd0});
        exp_q.push_back('{EV_DONE, 3'd0, 64'd0});
    endfunction

    task automatic drive_msg(input int n, input int gap, input logic [63:0] base);
        int guard;
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0) begin
                pkt_vld = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    tests_run++;
                    if (st_pkt !== 1'b0 || pkt_rdy !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL gap got st_pkt=%b pkt_rdy=%b, required 0 1", st_pkt, pkt_rdy);
                    end
                    @(posedge clk);
                    #1;
                end
            end
            pkt_vld = 1'b1;
            pkt_last = (i == n - 1);
            pkt_data = base + 64'(i);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 300) begin
                @(negedge clk);
                acc = pkt_rdy;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL accept_timeout got no accept for word %0d, required accept", i);
            end
        end
        pkt_vld = 1'b0;
        pkt_last = 1'b0;
    endtask

    task automatic send_msg(input int n, input int gap, input logic [63:0] base, input string name);
        int start;
        int guard;
        start = done_cnt;
        push_expect(n, base);
        drive_msg(n, gap, base);
        guard = 0;
        while (done_cnt == start && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        tests_run++;
        if (done_cnt != start + 1) begin
            tests_failed++;
            $display("FAIL %s_done got %0d msg_done pulses, required 1", name, done_cnt - start);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain got %0d pending events, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({pkt_rdy, st_pkt, pad_pkt, zero_pkt, mgln_pkt, clr, blk_vld, msg_done} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL reset_outputs got %b, required 10000000",
                     {pkt_rdy, st_pkt, pad_pkt, zero_pkt, mgln_pkt, clr, blk_vld, msg_done});
        end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_word();
        ack_delay = 0;
        send_msg(1, 0, 64'h0123_4567_89AB_CDEF, "one_word");
    endtask

    task automatic test_six_word();
        send_msg(6, 0, 64'h6000_0000_0000_0010, "six_word");
    endtask

    task automatic test_seven_word();
        send_msg(7, 0, 64'h7000_0000_0000_0100, "seven_word");
    endtask

    task automatic test_eight_word();
        send_msg(8, 0, 64'h8000_0000_0000_1000, "eight_word");
    endtask

    task automatic test_delayed_ack();
        ack_delay = 5;
        send_msg(9, 0, 64'h9000_0000_0001_0000, "delayed_ack");
        tests_run++;
        if (last_hold != 6) begin
            tests_failed++;
            $display("FAIL delayed_ack_hold got blk_vld for %0d cycles, required 6", last_hold);
        end
        ack_delay = 0;
    endtask

    task automatic test_gaps();
        send_msg(5, 3, 64'hA000_0000_0010_0000, "gaps");
    endtask

    task automatic test_ack_ignored();
        ack_auto = 1'b0;
        blk_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (pkt_rdy !== 1'b1 || blk_vld !== 1'b0 || st_pkt !== 1'b0) begin
                tests_failed++;
                $display("FAIL ack_idle got pkt_rdy=%b blk_vld=%b st_pkt=%b, required 1 0 0", pkt_rdy, blk_vld, st_pkt);
            end
            @(posedge clk);
            #1;
        end
        blk_ack = 1'b0;
        ack_auto = 1'b1;
        send_msg(2, 0, 64'hB000_0000_0100_0000, "after_idle_ack");
    endtask

    task automatic test_reset_mid_zero();
        int start;
        int guard;
        push_expect(1, 64'hC000_0000_1000_0000);
        start = zero_seen;
        drive_msg(1, 0, 64'hC000_0000_1000_0000);
        guard = 0;
        while (zero_seen < start + 2 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        tests_run++;
        if (zero_seen < start + 2) begin
            tests_failed++;
            $display("FAIL mid_zero_reach got %0d zero stores, required 2", zero_seen - start);
        end
        rst_b = 1'b0;
        #1;
        tests_run++;
        if ({pkt_rdy, st_pkt, pad_pkt, zero_pkt, mgln_pkt, clr, blk_vld, msg_done} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL mid_zero_reset got %b, required 10000000",
                     {pkt_rdy, st_pkt, pad_pkt, zero_pkt, mgln_pkt, clr, blk_vld, msg_done});
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        send_msg(1, 0, 64'hD000_0001_0000_0000, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_word();
        test_six_word();
        test_seven_word();
        test_eight_word();
        test_delayed_ack();
        test_gaps();
        test_ack_ignored();
        test_reset_mid_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sha2_pad_ctrl.md
SHA2_PAD_CTRL -- requirements
Module: sha2_pad_ctrl

Interface
REQ-001 SHALL have parameter: none; all widths fixed (64-bit words, 8-word/512-bit block, 3-bit index).
REQ-002 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_b  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: pkt_vld  in  1  upstream data word valid.
REQ-005 SHALL have port: pkt_last  in  1  qualifies the final word of a message, sampled with pkt_vld.
REQ-006 SHALL have port: pkt_rdy  out  1  controller accepts a data word this cycle.
REQ-007 SHALL have port: idx  in  3  current write slot from the input datapath counter.
REQ-008 SHALL have ports: st_pkt, pad_pkt, zero_pkt, mgln_pkt, clr  out  1 each  datapath controls (store, pad word 0x8000_0000_0000_0000, zero word, length word, clear).
REQ-009 SHALL have port: blk_vld  out  1  512-bit block complete and held stable.
REQ-010 SHALL have port: blk_ack  in  1  hash core consumed the block.
REQ-011 SHALL have port: msg_done  out  1  one-cycle pulse at end of message.

Function
REQ-012 SHALL implement the FSM states IDLE, DATA, PAD, ZERO, LEN, BLK, DONE.
REQ-013 SHALL drive pkt_rdy=1 only in IDLE and DATA; a word is accepted when pkt_vld&pkt_rdy, producing st_pkt=1 in the same cycle with all other datapath controls at 0.
REQ-014 SHALL move IDLE->DATA on the first accepted word; every message contains at least one data word.
REQ-015 SHALL, on the accepted word with pkt_last=1, go to PAD; if that word was stored at idx=7, go instead to BLK with resume state PAD.
REQ-016 SHALL, in PAD/ZERO/LEN, assert st_pkt with exactly one of pad_pkt/zero_pkt/mgln_pkt for one cycle per stored word; no upstream word is accepted.
REQ-017 SHALL set the next state after a PAD or ZERO store at idx=6 to LEN, at idx=7 to BLK with resume ZERO, and otherwise to ZERO.
REQ-018 SHALL perform the LEN store only at idx=7, then go to BLK with resume DONE.
REQ-019 SHALL, on any store at idx=7, enter BLK the next cycle: blk_vld=1, st_pkt=0, pkt_rdy=0; hold until blk_ack=1, then go to the resume state in the following cycle.
REQ-020 SHALL ignore blk_ack outside BLK.
REQ-021 SHALL, in DONE, pulse clr=1 and msg_done=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL drive all outputs from registered state or state-plus-input decode, with no combinational path from blk_ack to st_pkt.
REQ-023 SHALL resolve a DATA word with idx=7 and pkt_last=0 as: BLK with resume DATA.

Reset
REQ-024 SHALL, on rst_b=0 at any time (including mid-message), force IDLE, all outputs 0 except pkt_rdy=1, and clear the resume register.

Configuration
REQ-025 SHALL, with SHA2_BLK_CNT_EN defined, add output blk_cnt[15:0]: blocks acknowledged in the current message, zeroed in DONE and on reset, saturating at 0xFFFF.
REQ-026 SHALL, without SHA2_BLK_CNT_EN defined, omit the blk_cnt port and counter entirely.

Structure
REQ-027 SHALL take the state enumeration typedef, PAD_WORD and the idx constant IDX_LAST=7 from shared package sha2_pkg.
REQ-028 SHALL be a single FSM module with no sub-modules; the top level instantiates it beside sha2indpath.

Verification
REQ-029 SHALL cover: 1-word message 0x0123456789ABCDEF -> data@0, pad@1, zero@2..6, len@7 (=64); blk_vld; ack -> msg_done pulse.
REQ-030 SHALL cover: 7-word message -> pad@7, BLK; ack -> zero@0..6, len@7 (=448), second BLK, msg_done.
REQ-031 SHALL cover: 8-word message -> BLK after data@7; ack -> pad@0, zero@1..6, len@7 (=512).
REQ-032 SHALL cover: blk_ack delayed 5 cycles -> blk_vld held 5+ cycles, pkt_rdy=0, no st_pkt.
REQ-033 SHALL cover: pkt_vld gaps of 3 cycles within DATA -> no st_pkt during gaps, idx unchanged.
REQ-034 SHALL cover: rst_b low during ZERO -> immediate IDLE, outputs per REQ-024; next message starts cleanly at idx=0.
